m68k_bus_if: RTL and testbench

M68K_BUS_IF -- requirements
Module: m68k_bus_if

---
 rtl/m68k_pkg.sv | 19 +
 rtl/sync2.sv | 27 ++
 rtl/m68k_bus_if.sv | 184 ++++++++++++++++++
 tb/tb_m68k_bus_if.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_pkg.sv
// Shared constants and state encoding for the 68000-to-SRAM bus bridge.
package m68k_pkg;

    localparam int unsigned CPU_ADDR_W             = 23;
    localparam int unsigned DATA_W                 = 16;
    localparam int unsigned MEM_ADDR_W             = 20;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    // Size of the SRAM window minus one (1 MiB of byte addresses).
    localparam logic [MEM_ADDR_W-1:0] SRAM_WINDOW  = 20'hFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2,
        ST_BERR   = 2'd3
    } bus_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous control input.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Both stages reset to the idle (negated) level of the input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/m68k_bus_if.sv
// 68000 asynchronous bus slave bridging CPU cycles onto a handshaked SRAM port.
module m68k_bus_if
    import m68k_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter logic [23:0] SRAM_BASE      = 24'h000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_as_n,
    input  logic                  cpu_uds_n,
    input  logic                  cpu_lds_n,
    input  logic                  cpu_rw,
    input  logic [CPU_ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_data_out,
    output logic [DATA_W-1:0]     cpu_data_in,
    output logic                  cpu_data_oe,
    output logic                  cpu_dtack_n,
    output logic                  cpu_berr_n,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_uds,
    output logic                  mem_lds,
    output logic                  mem_rw,
    output logic [DATA_W-1:0]     mem_data_write,
    input  logic [DATA_W-1:0]     mem_data_read,
    input  logic                  mem_ack
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic as_s_n;
    logic uds_s_n;
    logic lds_s_n;

    sync2 #(.RST_VAL(1'b1)) u_sync_as  (.clk(clk), .reset(reset), .d(cpu_as_n),  .q(as_s_n));
    sync2 #(.RST_VAL(1'b1)) u_sync_uds (.clk(clk), .reset(reset), .d(cpu_uds_n), .q(uds_s_n));
    sync2 #(.RST_VAL(1'b1)) u_sync_lds (.clk(clk), .reset(reset), .d(cpu_lds_n), .q(lds_s_n));

    bus_state_t              state_q,       state_d;
    logic [CNT_W-1:0]        cnt_q,         cnt_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q,    mem_addr_d;
    logic                    mem_uds_q,     mem_uds_d;
    logic                    mem_lds_q,     mem_lds_d;
    logic                    mem_rw_q,      mem_rw_d;
    logic [DATA_W-1:0]       mem_wdata_q,   mem_wdata_d;
    logic [DATA_W-1:0]       cpu_rdata_q,   cpu_rdata_d;
    logic                    data_oe_q,     data_oe_d;
    logic                    dtack_n_q,     dtack_n_d;
    logic                    berr_n_q,      berr_n_d;

    logic [23:0]             byte_addr_c;
    logic [23:0]             rel_addr_c;
    logic                    in_window_c;
    logic                    ds_any_c;
    logic                    cyc_qual_c;
    logic [CNT_W-1:0]        cnt_inc_c;
    logic                    timeout_c;

    // Address decode and cycle qualification from the synchronised strobes.
    always_comb begin
        byte_addr_c = {cpu_addr, 1'b0};
        rel_addr_c  = byte_addr_c - SRAM_BASE;
        in_window_c = (rel_addr_c <= 24'(SRAM_WINDOW));
        ds_any_c    = !uds_s_n || !lds_s_n;
        cyc_qual_c  = !as_s_n && ds_any_c;
        cnt_inc_c   = cnt_q + CNT_W'(1);
        timeout_c   = (cnt_inc_c == CNT_W'(TIMEOUT_CYCLES));
    end

    // State and output registers; reset drops strobes and handshakes at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_uds_q   <= 1'b0;
            mem_lds_q   <= 1'b0;
            mem_rw_q    <= 1'b1;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            data_oe_q   <= 1'b0;
            dtack_n_q   <= 1'b1;
            berr_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_uds_q   <= mem_uds_d;
            mem_lds_q   <= mem_lds_d;
            mem_rw_q    <= mem_rw_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            data_oe_q   <= data_oe_d;
            dtack_n_q   <= dtack_n_d;
            berr_n_q    <= berr_n_d;
        end
    end

    // Next-state and registered-output logic for the bus cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_uds_d   = mem_uds_q;
        mem_lds_d   = mem_lds_q;
        mem_rw_d    = mem_rw_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        data_oe_d   = data_oe_q;
        dtack_n_d   = dtack_n_q;
        berr_n_d    = berr_n_q;

        case (state_q)
            ST_IDLE: begin
                // AS alone is not enough: on writes DS trails AS.
                if (cyc_qual_c) begin
                    if (!in_window_c) begin
                        berr_n_d = 1'b0;
                        state_d  = ST_BERR;
                    end else begin
                        cnt_d       = '0;
                        mem_addr_d  = rel_addr_c[MEM_ADDR_W-1:0];
                        mem_uds_d   = !uds_s_n;
                        mem_lds_d   = !lds_s_n;
                        mem_rw_d    = cpu_rw;
                        mem_wdata_d = cpu_rw ? '0 : cpu_data_out;
                        state_d     = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_inc_c;
                if (as_s_n || !ds_any_c) begin
                    // CPU abandoned the cycle: quietly release the SRAM.
                    mem_uds_d = 1'b0;
                    mem_lds_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (mem_ack) begin
                    // Ack takes priority over a coincident timeout.
                    mem_uds_d = 1'b0;
                    mem_lds_d = 1'b0;
                    if (mem_rw_q) begin
                        cpu_rdata_d = mem_data_read;
                    end
                    data_oe_d = mem_rw_q;
                    dtack_n_d = 1'b0;
                    state_d   = ST_ACK;
                end else if (timeout_c) begin
                    mem_uds_d = 1'b0;
                    mem_lds_d = 1'b0;
                    berr_n_d  = 1'b0;
                    state_d   = ST_BERR;
                end
            end
            ST_ACK: begin
                if (as_s_n) begin
                    dtack_n_d = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_BERR: begin
                if (as_s_n) begin
                    berr_n_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cpu_data_in    = cpu_rdata_q;
    assign cpu_data_oe    = data_oe_q;
    assign cpu_dtack_n    = dtack_n_q;
    assign cpu_berr_n     = berr_n_q;
    assign mem_addr       = mem_addr_q;
    assign mem_uds        = mem_uds_q;
    assign mem_lds        = mem_lds_q;
    assign mem_rw         = mem_rw_q;
    assign mem_data_write = mem_wdata_q;

endmodule

// File: tb/tb_m68k_bus_if.sv
// Directed and randomized bench for m68k_bus_if against a transaction-level model.
module tb_m68k_bus_if;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
    logic [22:0] cpu_addr;
    logic [15:0] cpu_data_out, cpu_data_in;
    logic        cpu_data_oe, cpu_dtack_n, cpu_berr_n;
    logic [19:0] mem_addr;
    logic        mem_uds, mem_lds, mem_rw;
    logic [15:0] mem_data_write, mem_data_read;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m68k_bus_if #(.TIMEOUT_CYCLES(T), .SRAM_BASE(24'h000000)) dut (
        .clk(clk), .reset(reset),
        .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
        .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
        .cpu_data_in(cpu_data_in), .cpu_data_oe(cpu_data_oe),
        .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n),
        .mem_addr(mem_addr), .mem_uds(mem_uds), .mem_lds(mem_lds), .mem_rw(mem_rw),
        .mem_data_write(mem_data_write), .mem_data_read(mem_data_read), .mem_ack(mem_ack)
    );

    // Expected behaviour of one CPU transaction, derived from the bus rules.
    typedef struct {
        bit          in_win;
        bit          ok;
        logic [19:0] maddr;
        bit          uds;
        bit          lds;
        bit          rw;
        logic [15:0] wdata;
        int          access_cycles;
    } exp_t;

    function automatic exp_t model(input logic [23:0] baddr, input bit rw, input bit uds_n,
                                   input bit lds_n, input logic [15:0] wd, input int ack_delay);
        exp_t e;
        e.in_win = (baddr < 24'h100000);
        e.maddr  = {baddr[19:1], 1'b0};
        e.uds    = !uds_n;
        e.lds    = !lds_n;
        e.rw     = rw;
        e.wdata  = rw ? 16'h0000 : wd;
        // The ack is seen in ACCESS cycle ack_delay+1; the timeout allows T cycles.
        if (!e.in_win) begin
            e.ok = 0; e.access_cycles = 0;
        end else if (ack_delay + 1 <= int'(T)) begin
            e.ok = 1; e.access_cycles = ack_delay + 1;
        end else begin
            e.ok = 0; e.access_cycles = int'(T);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " dtack_n"}, 32'(cpu_dtack_n), 32'd1);
        chk({tag, " berr_n"},  32'(cpu_berr_n),  32'd1);
        chk({tag, " oe"},      32'(cpu_data_oe), 32'd0);
        chk({tag, " din"},     32'(cpu_data_in), 32'd0);
        chk({tag, " uds"},     32'(mem_uds),     32'd0);
        chk({tag, " lds"},     32'(mem_lds),     32'd0);
        chk({tag, " rw"},      32'(mem_rw),      32'd1);
        chk({tag, " maddr"},   32'(mem_addr),    32'd0);
        chk({tag, " wdata"},   32'(mem_data_write), 32'd0);
    endtask

    task automatic cpu_negate();
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
    endtask

    // One full CPU cycle with an SRAM responder that acks ack_delay clocks after the strobes.
    task automatic cpu_cycle(input string tag, input logic [23:0] baddr, input bit rw,
                             input bit uds_n, input bit lds_n, input logic [15:0] wd,
                             input logic [15:0] rd, input int ds_delay, input int ack_delay);
        exp_t e;
        int   first_strobe = -1;
        int   strobe_cycles = 0;
        int   resp_at = -1;
        int   ack_set_at = -1;
        bit   got_dtack = 0;
        bit   got_berr = 0;
        e = model(baddr, rw, uds_n, lds_n, wd, ack_delay);

        @(negedge clk);
        cpu_addr     = baddr[23:1];
        cpu_rw       = rw;
        cpu_data_out = wd;
        cpu_as_n     = 1'b0;
        if (ds_delay == 0) begin
            cpu_uds_n = uds_n;
            cpu_lds_n = lds_n;
        end
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == ds_delay) begin
                cpu_uds_n = uds_n;
                cpu_lds_n = lds_n;
            end
            if (mem_uds || mem_lds) begin
                if (first_strobe < 0) begin
                    first_strobe = n;
                    chk({tag, " mem_addr"},  32'(mem_addr),       32'(e.maddr));
                    chk({tag, " mem_uds"},   32'(mem_uds),        32'(e.uds));
                    chk({tag, " mem_lds"},   32'(mem_lds),        32'(e.lds));
                    chk({tag, " mem_rw"},    32'(mem_rw),         32'(e.rw));
                    chk({tag, " mem_wdata"}, 32'(mem_data_write), 32'(e.wdata));
                end
                strobe_cycles++;
                if (strobe_cycles == ack_delay + 1) begin
                    mem_ack       = 1'b1;
                    mem_data_read = rd;
                    ack_set_at    = n;
                end
            end else begin
                mem_ack = 1'b0;
            end
            if (!cpu_dtack_n || !cpu_berr_n) begin
                resp_at   = n;
                got_dtack = !cpu_dtack_n;
                got_berr  = !cpu_berr_n;
                break;
            end
        end

        chk({tag, " dtack"}, 32'(got_dtack), 32'(e.ok));
        chk({tag, " berr"},  32'(got_berr),  32'(!e.ok));
        chk({tag, " strobes_off_at_resp"}, 32'({mem_uds, mem_lds}), 32'd0);
        chk({tag, " access_cycles"}, 32'(strobe_cycles), 32'(e.access_cycles));
        if (e.in_win) begin
            chk({tag, " first_strobe"}, 32'(first_strobe), 32'(ds_delay + 3));
        end else begin
            chk({tag, " berr_time"}, 32'(resp_at), 32'(ds_delay + 3));
        end
        if (e.ok) begin
            chk({tag, " dtack_latency"}, 32'(resp_at), 32'(ack_set_at + 1));
            chk({tag, " oe"}, 32'(cpu_data_oe), 32'(rw));
            if (rw) chk({tag, " rdata"}, 32'(cpu_data_in), 32'(rd));
        end

        // Release: response must hold until the negated AS is synchronised.
        @(negedge clk);
        mem_ack = 1'b0;
        cpu_negate();
        repeat (2) @(negedge clk);
        chk({tag, " hold"}, 32'(cpu_dtack_n & cpu_berr_n), 32'd0);
        @(negedge clk);
        chk({tag, " release"}, 32'({cpu_dtack_n, cpu_berr_n, cpu_data_oe}), 32'b110);
        @(negedge clk);
    endtask

    initial begin
        bit  seen;
        bit  resp;
        logic [23:0] ra;
        int  sel;

        reset = 1'b1;
        cpu_negate();
        cpu_rw        = 1'b1;
        cpu_addr      = '0;
        cpu_data_out  = '0;
        mem_data_read = '0;
        mem_ack       = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        cpu_cycle("word_read",   24'h000100, 1'b1, 1'b0, 1'b0, 16'h1234, 16'hBEEF, 0, 3);
        cpu_cycle("byte_write",  24'h000201, 1'b0, 1'b1, 1'b0, 16'h00A5, 16'h0000, 0, 1);
        cpu_cycle("ds_trail",    24'h00ABC4, 1'b0, 1'b0, 1'b0, 16'h5A5A, 16'h0000, 3, 2);
        cpu_cycle("out_window",  24'h200000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 0);
        cpu_cycle("timeout",     24'h000400, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1111, 0, 100);
        cpu_cycle("ack_at_tmo",  24'h000402, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h2222, 0, int'(T) - 1);
        cpu_cycle("ack_late",    24'h000404, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h3333, 0, int'(T));
        cpu_cycle("win_top",     24'h0FFFFE, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hC0DE, 1, 0);
        cpu_cycle("win_above",   24'h100000, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h0000, 0, 0);

        // Aborted cycle: CPU drops strobes while SRAM never acks.
        @(negedge clk);
        cpu_addr = 23'h000300; cpu_rw = 1'b1;
        cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = mem_uds && mem_lds;
        end
        chk("abort strobe_seen", 32'(seen), 32'd1);
        cpu_negate();
        resp = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (!cpu_dtack_n || !cpu_berr_n) resp = 1;
        end
        chk("abort no_resp", 32'(resp), 32'd0);
        chk("abort strobes_off", 32'({mem_uds, mem_lds}), 32'd0);
        cpu_cycle("after_abort", 24'h000306, 1'b0, 1'b0, 1'b0, 16'hCAFE, 16'h0000, 0, 2);

        // Reset in the middle of an access: outputs clear without a clock edge.
        @(negedge clk);
        cpu_addr = 23'h000500; cpu_rw = 1'b0; cpu_data_out = 16'h9999;
        cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = mem_uds && mem_lds;
        end
        chk("midrst strobe_seen", 32'(seen), 32'd1);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        cpu_negate();
        repeat (3) @(negedge clk);
        cpu_cycle("after_reset", 24'h000502, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h4242, 0, 1);

        // Randomized transactions checked against the model.
        for (int i = 0; i < 40; i++) begin
            ra = {($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                  20'($urandom)};
            ra[0] = 1'b0;
            sel = int'($urandom_range(0, 2));
            cpu_cycle($sformatf("rnd%0d", i), ra, 1'($urandom),
                      (sel == 2), (sel == 1), 16'($urandom), 16'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, T + 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
